// File: rtl/pc_sequencer_if.sv
// Fetch/decode control bundle for pc_sequencer; master is the sequencer,
// slave is the instruction memory plus decode stage.
interface pc_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic        instr_valid;
  logic        resolve_valid;
  logic [2:0]  branch_type;
  logic        zero;
  logic        sign;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        stall;
  logic        flush;
  logic [31:0] pc;

  modport master (
    output imem_req, imem_addr, instr_valid, flush, pc,
    input  imem_ack, resolve_valid, branch_type, zero, sign,
           branch_target, jump, jump_target, stall
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, flush, pc,
    output imem_ack, resolve_valid, branch_type, zero, sign,
           branch_target, jump, jump_target, stall
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: IDLE/FETCH/DECODE loop with branch/jump redirect.
// Define DELAY_SLOT_EN for MIPS branch-delay-slot semantics (no flush).
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0040_0000
) (
  input  logic           clk,
  input  logic           rst,
  pc_sequencer_if.master bus
);

  typedef enum logic [1:0] {IDLE, FETCH, DECODE} state_t;

  state_t      state, state_nx;
  logic [31:0] pc_q, pc_nx;
  logic        iv_q, iv_nx;
  logic        flush_q, flush_nx;
  logic        taken, redirect;
  logic [31:0] seq_pc, ctl_tgt;
`ifdef DELAY_SLOT_EN
  logic        pend_q, pend_nx;
  logic [31:0] ptgt_q, ptgt_nx;
`endif

  always_comb begin
    taken = 1'b0;
    case (bus.branch_type)
      3'b001:  taken = bus.zero;
      3'b010:  taken = !bus.zero;
      3'b011:  taken = !bus.sign;
      3'b100:  taken = !bus.sign && !bus.zero;
      3'b101:  taken = bus.sign || bus.zero;
      3'b110:  taken = bus.sign && !bus.zero;
      default: taken = 1'b0;
    endcase
  end

  assign seq_pc   = pc_q + 32'd4;
  assign redirect = bus.jump || taken;
  assign ctl_tgt  = bus.jump ? {bus.jump_target[31:2], 2'b00}
                             : {bus.branch_target[31:2], 2'b00};

  always_comb begin
    state_nx = state;
    pc_nx    = pc_q;
    iv_nx    = 1'b0;
    // A stalled FETCH keeps a pending flush pulse visible alongside imem_req.
    flush_nx = (bus.stall && state == FETCH) ? flush_q : 1'b0;
`ifdef DELAY_SLOT_EN
    pend_nx  = pend_q;
    ptgt_nx  = ptgt_q;
`endif
    case (state)
      IDLE: state_nx = FETCH;
      FETCH: begin
        if (bus.imem_ack && !bus.stall) begin
          state_nx = DECODE;
          iv_nx    = 1'b1;
        end
      end
      DECODE: begin
        if (bus.resolve_valid && !bus.stall) begin
          state_nx = FETCH;
`ifdef DELAY_SLOT_EN
          // The delay-slot decode retires into the latched target; its own decision is dropped.
          if (pend_q) begin
            pc_nx   = ptgt_q;
            pend_nx = 1'b0;
          end else begin
            pc_nx = seq_pc;
            if (redirect) begin
              pend_nx = 1'b1;
              ptgt_nx = ctl_tgt;
            end
          end
`else
          pc_nx    = redirect ? ctl_tgt : seq_pc;
          flush_nx = redirect;
`endif
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pc_q    <= RESET_VECTOR;
      iv_q    <= 1'b0;
      flush_q <= 1'b0;
`ifdef DELAY_SLOT_EN
      pend_q  <= 1'b0;
      ptgt_q  <= '0;
`endif
    end else begin
      state   <= state_nx;
      pc_q    <= pc_nx;
      iv_q    <= iv_nx;
      flush_q <= flush_nx;
`ifdef DELAY_SLOT_EN
      pend_q  <= pend_nx;
      ptgt_q  <= ptgt_nx;
`endif
    end
  end

  assign bus.imem_req    = (state == FETCH);
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = iv_q;
  assign bus.flush       = flush_q;
  assign bus.pc          = pc_q;

endmodule
